// File: rtl/vend_pkg.sv
// Shared types and constants for the parametrised vending datapath.
package vend_pkg;

  // Transaction states: credit empty, credit held, one-cycle vend, change drain.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  // Error codes reported alongside the one-cycle error pulse.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INSUFF  = 2'b01;
  localparam logic [1:0] ERR_SOLDOUT = 2'b10;
  localparam logic [1:0] ERR_REJECT  = 2'b11;

  // Selector width; a single item still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when an item index addresses a real table entry.
  function automatic logic idx_ok(input int idx, input int n);
    return (idx < n);
  endfunction

endpackage

// File: rtl/vend_datapath_n_if.sv
// Front-end / back-end signal bundle of the vending datapath.
interface vend_datapath_n_if
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int PRICE_W   = 8,
  parameter int MONEY_W   = 3,
  parameter int STOCK_W   = 4
) ();
  localparam int SEL_W = sel_width(NUM_ITEMS);

  logic [MONEY_W-1:0]   money;
  logic                 money_valid;
  logic [SEL_W-1:0]     sel;
  logic                 buy;
  logic                 cancel;
  logic                 prog_en;
  logic [SEL_W-1:0]     prog_idx;
  logic [PRICE_W-1:0]   prog_price;
  logic [STOCK_W-1:0]   prog_stock;
  logic                 chg_ready;
  logic                 dispense;
  logic [SEL_W-1:0]     dispense_idx;
  logic                 error;
  logic [1:0]           err_code;
  logic [PRICE_W-1:0]   balance;
  logic                 chg_valid;
  logic [MONEY_W-1:0]   chg_amt;
  logic                 busy;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output money, money_valid, sel, buy, cancel, prog_en, prog_idx, prog_price,
           prog_stock, chg_ready,
    input  dispense, dispense_idx, error, err_code, balance, chg_valid, chg_amt,
           busy, sold_out
  );

  modport slave (
    input  money, money_valid, sel, buy, cancel, prog_en, prog_idx, prog_price,
           prog_stock, chg_ready,
    output dispense, dispense_idx, error, err_code, balance, chg_valid, chg_amt,
           busy, sold_out
  );
endinterface

// File: rtl/vend_item_table.sv
// Per-item price/stock register file with program and decrement ports.
module vend_item_table
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2,
  parameter int PRICE_W   = 8,
  parameter int STOCK_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [SEL_W-1:0]     wr_idx_i,
  input  logic [PRICE_W-1:0]   wr_price_i,
  input  logic [STOCK_W-1:0]   wr_stock_i,
  input  logic                 dec_en_i,
  input  logic [SEL_W-1:0]     dec_idx_i,
  input  logic [SEL_W-1:0]     rd_idx_i,
  output logic [PRICE_W-1:0]   rd_price_o,
  output logic [STOCK_W-1:0]   rd_stock_o,
  output logic                 rd_hit_o,
  output logic [NUM_ITEMS-1:0] sold_out_o
);
  logic [PRICE_W-1:0]   price_q [NUM_ITEMS];
  logic [PRICE_W-1:0]   price_d [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_out_q;
  logic [NUM_ITEMS-1:0] sold_out_d;

  // Next table contents: a program write replaces an entry, a vend decrements
  // its stock; out-of-range indices match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price_d[i] = price_q[i];
      stock_d[i] = stock_q[i];
      if (wr_en_i && (wr_idx_i == SEL_W'(i))) begin
        price_d[i] = wr_price_i;
        stock_d[i] = wr_stock_i;
      end else if (dec_en_i && (dec_idx_i == SEL_W'(i)) && (stock_q[i] != {STOCK_W{1'b0}})) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end else begin
        stock_d[i] = stock_q[i];
      end
      sold_out_d[i] = (stock_d[i] == {STOCK_W{1'b0}});
    end
  end

  // Table storage; reset empties every item so all read as sold out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= {PRICE_W{1'b0}};
        stock_q[i] <= {STOCK_W{1'b0}};
      end
      sold_out_q <= {NUM_ITEMS{1'b1}};
    end else begin
      price_q    <= price_d;
      stock_q    <= stock_d;
      sold_out_q <= sold_out_d;
    end
  end

  // Combinational lookup of the selected item; a missing index reads as empty.
  always_comb begin
    rd_hit_o = idx_ok(int'(rd_idx_i), NUM_ITEMS);
    if (rd_hit_o) begin
      rd_price_o = price_q[rd_idx_i];
      rd_stock_o = stock_q[rd_idx_i];
    end else begin
      rd_price_o = {PRICE_W{1'b0}};
      rd_stock_o = {STOCK_W{1'b0}};
    end
  end

  assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vend_datapath_n.sv
// N-item vending datapath: credit, vend, error pulses and beat-wise change.
module vend_datapath_n
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int PRICE_W   = 8,
  parameter int MONEY_W   = 3,
  parameter int STOCK_W   = 4,
  parameter int MAX_COIN  = 5
) (
  input logic             clk,
  input logic             reset,
  vend_datapath_n_if.slave bus
);
  localparam int SEL_W = sel_width(NUM_ITEMS);
  localparam logic [PRICE_W-1:0] MAX_COIN_P = PRICE_W'(MAX_COIN);
  localparam logic [MONEY_W-1:0] MAX_COIN_M = MONEY_W'(MAX_COIN);

  state_t               state_q, state_d;
  logic [PRICE_W-1:0]   balance_q, balance_d;
  logic                 dispense_q, dispense_d;
  logic [SEL_W-1:0]     dispense_idx_q, dispense_idx_d;
  logic                 error_q, error_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 chg_valid_q, chg_valid_d;
  logic [MONEY_W-1:0]   chg_amt_q, chg_amt_d;
  logic                 busy_q, busy_d;

  logic                 wr_en_s;
  logic                 dec_en_s;
  logic [PRICE_W-1:0]   rd_price_s;
  logic [STOCK_W-1:0]   rd_stock_s;
  logic                 rd_hit_s;
  logic [NUM_ITEMS-1:0] sold_out_s;
  logic [PRICE_W:0]     sum_s;
  logic [PRICE_W-1:0]   remain_s;

  // Largest coin the hopper may pay out of a given credit.
  function automatic logic [MONEY_W-1:0] coin_for(input logic [PRICE_W-1:0] bal);
    if (bal > MAX_COIN_P) begin
      return MAX_COIN_M;
    end else begin
      return bal[MONEY_W-1:0];
    end
  endfunction

  vend_item_table #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .PRICE_W   (PRICE_W),
    .STOCK_W   (STOCK_W)
  ) u_items (
    .clk        (clk),
    .rst_n      (reset),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (bus.prog_idx),
    .wr_price_i (bus.prog_price),
    .wr_stock_i (bus.prog_stock),
    .dec_en_i   (dec_en_s),
    .dec_idx_i  (bus.sel),
    .rd_idx_i   (bus.sel),
    .rd_price_o (rd_price_s),
    .rd_stock_o (rd_stock_s),
    .rd_hit_o   (rd_hit_s),
    .sold_out_o (sold_out_s)
  );

  // One extra bit catches credit overflow; remain_s is credit after a paid beat.
  assign sum_s    = {1'b0, balance_q} + (PRICE_W+1)'(bus.money);
  assign remain_s = balance_q - PRICE_W'(chg_amt_q);

  // Next-state and output decode; pulses default low, change offer holds.
  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    dispense_d     = 1'b0;
    dispense_idx_d = {SEL_W{1'b0}};
    error_d        = 1'b0;
    err_code_d     = ERR_NONE;
    chg_valid_d    = chg_valid_q;
    chg_amt_d      = chg_amt_q;
    wr_en_s        = 1'b0;
    dec_en_s       = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel) begin
          if (state_q == COLLECT) begin
            state_d     = CHANGE;
            chg_valid_d = 1'b1;
            chg_amt_d   = coin_for(balance_q);
          end else begin
            state_d = IDLE;
          end
        end else if (bus.buy) begin
          if (!rd_hit_s || (rd_stock_s == {STOCK_W{1'b0}})) begin
            error_d    = 1'b1;
            err_code_d = ERR_SOLDOUT;
          end else if (balance_q < rd_price_s) begin
            error_d    = 1'b1;
            err_code_d = ERR_INSUFF;
          end else begin
            balance_d      = balance_q - rd_price_s;
            dec_en_s       = 1'b1;
            dispense_d     = 1'b1;
            dispense_idx_d = bus.sel;
            state_d        = DISPENSE;
          end
        end else if (bus.money_valid) begin
          if (sum_s[PRICE_W]) begin
            error_d    = 1'b1;
            err_code_d = ERR_REJECT;
          end else begin
            balance_d = sum_s[PRICE_W-1:0];
            state_d   = (sum_s != {(PRICE_W+1){1'b0}}) ? COLLECT : state_q;
          end
        end else if (bus.prog_en && (state_q == IDLE)) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      DISPENSE: begin
        error_d    = bus.money_valid;
        err_code_d = bus.money_valid ? ERR_REJECT : ERR_NONE;
        if (balance_q != {PRICE_W{1'b0}}) begin
          state_d     = CHANGE;
          chg_valid_d = 1'b1;
          chg_amt_d   = coin_for(balance_q);
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        error_d    = bus.money_valid;
        err_code_d = bus.money_valid ? ERR_REJECT : ERR_NONE;
        if (!chg_valid_q) begin
          // Defensive: an unoffered CHANGE either re-offers or gives up.
          if (balance_q == {PRICE_W{1'b0}}) begin
            state_d = IDLE;
          end else begin
            chg_valid_d = 1'b1;
            chg_amt_d   = coin_for(balance_q);
          end
        end else if (bus.chg_ready) begin
          balance_d = remain_s;
          if (remain_s == {PRICE_W{1'b0}}) begin
            chg_valid_d = 1'b0;
            chg_amt_d   = {MONEY_W{1'b0}};
            state_d     = IDLE;
          end else begin
            chg_amt_d = coin_for(remain_s);
          end
        end else begin
          chg_amt_d = chg_amt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        chg_valid_d = 1'b0;
        chg_amt_d   = {MONEY_W{1'b0}};
      end
    endcase
    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      balance_q      <= {PRICE_W{1'b0}};
      dispense_q     <= 1'b0;
      dispense_idx_q <= {SEL_W{1'b0}};
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
      chg_valid_q    <= 1'b0;
      chg_amt_q      <= {MONEY_W{1'b0}};
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      dispense_q     <= dispense_d;
      dispense_idx_q <= dispense_idx_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      chg_valid_q    <= chg_valid_d;
      chg_amt_q      <= chg_amt_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.dispense     = dispense_q;
  assign bus.dispense_idx = dispense_idx_q;
  assign bus.error        = error_q;
  assign bus.err_code     = err_code_q;
  assign bus.balance      = balance_q;
  assign bus.chg_valid    = chg_valid_q;
  assign bus.chg_amt      = chg_amt_q;
  assign bus.busy         = busy_q;
  assign bus.sold_out     = sold_out_s;

endmodule

// File: tb/tb_vend_datapath_n.sv
// Directed, table-driven bench for vend_datapath_n (default parameters).
module tb_vend_datapath_n;

  typedef struct packed {
    logic       mv;
    logic [2:0] money;
    logic [1:0] sel;
    logic       buy;
    logic       cancel;
    logic       prog_en;
    logic [1:0] pidx;
    logic [7:0] pprice;
    logic [3:0] pstock;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       disp;
    logic [1:0] idx;
    logic       err;
    logic [1:0] code;
    logic [7:0] bal;
    logic       cv;
    logic [2:0] amt;
    logic       busy;
    logic [3:0] so;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vend_datapath_n_if #(.NUM_ITEMS(4), .PRICE_W(8), .MONEY_W(3), .STOCK_W(4)) bus ();

  vend_datapath_n #(
    .NUM_ITEMS(4), .PRICE_W(8), .MONEY_W(3), .STOCK_W(4), .MAX_COIN(5)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic in_t NOP(input logic rdy);
    in_t v;
    v = '0;
    v.rdy = rdy;
    return v;
  endfunction

  function automatic in_t COIN(input logic [2:0] m, input logic rdy);
    in_t v;
    v = NOP(rdy);
    v.mv = 1'b1;
    v.money = m;
    return v;
  endfunction

  function automatic in_t BUY(input logic [1:0] s);
    in_t v;
    v = NOP(1'b0);
    v.buy = 1'b1;
    v.sel = s;
    return v;
  endfunction

  function automatic in_t CANCEL(input logic rdy);
    in_t v;
    v = NOP(rdy);
    v.cancel = 1'b1;
    return v;
  endfunction

  function automatic in_t PROG(input logic [1:0] idx, input logic [7:0] price, input logic [3:0] stock);
    in_t v;
    v = NOP(1'b0);
    v.prog_en = 1'b1;
    v.pidx = idx;
    v.pprice = price;
    v.pstock = stock;
    return v;
  endfunction

  function automatic out_t O(input logic disp, input logic [1:0] idx, input logic err,
                             input logic [1:0] code, input logic [7:0] bal, input logic cv,
                             input logic [2:0] amt, input logic busy, input logic [3:0] so);
    out_t o;
    o.disp = disp; o.idx = idx; o.err = err; o.code = code; o.bal = bal;
    o.cv = cv; o.amt = amt; o.busy = busy; o.so = so;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("disp=%0d idx=%0d err=%0d code=%0d bal=%0d cv=%0d amt=%0d busy=%0d so=%b",
                     o.disp, o.idx, o.err, o.code, o.bal, o.cv, o.amt, o.busy, o.so);
  endfunction

  task automatic add(input in_t i, input out_t o, input string n);
    vec_t v;
    v.i = i; v.o = o; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t v);
    bus.money_valid = v.mv;
    bus.money       = v.money;
    bus.sel         = v.sel;
    bus.buy         = v.buy;
    bus.cancel      = v.cancel;
    bus.prog_en     = v.prog_en;
    bus.prog_idx    = v.pidx;
    bus.prog_price  = v.pprice;
    bus.prog_stock  = v.pstock;
    bus.chg_ready   = v.rdy;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t a;
    a = O(bus.dispense, bus.dispense_idx, bus.error, bus.err_code, bus.balance,
          bus.chg_valid, bus.chg_amt, bus.busy, bus.sold_out);
    n_vec++;
    if (a !== exp) begin
      n_miss++;
      $display("FAIL %s: got %s | want %s", name, fmt(a), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input in_t v, input string name, input out_t exp);
    drive(v);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int total;

    drive(NOP(1'b0));
    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1111));
    @(negedge clk);
    rst_n = 1'b1;

    // Vend with change, then empty item 1 through a second exact-price vend.
    add(PROG(0, 5, 2),  O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1110), "prog0");
    add(PROG(1, 7, 2),  O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1100), "prog1");
    add(PROG(2, 8, 2),  O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1000), "prog2");
    add(PROG(3, 10, 2), O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000), "prog3");
    add(COIN(4, 1),     O(0, 0, 0, 2'b00, 4, 0, 0, 0, 4'b0000), "coin4a");
    add(COIN(4, 1),     O(0, 0, 0, 2'b00, 8, 0, 0, 0, 4'b0000), "coin4b");
    add(BUY(1),         O(1, 1, 0, 2'b00, 1, 0, 0, 1, 4'b0000), "buy1_disp");
    add(NOP(1),         O(0, 0, 0, 2'b00, 1, 1, 1, 1, 4'b0000), "chg_beat1");
    add(NOP(1),         O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000), "chg_done");
    add(COIN(7, 1),     O(0, 0, 0, 2'b00, 7, 0, 0, 0, 4'b0000), "coin7");
    add(BUY(1),         O(1, 1, 0, 2'b00, 0, 0, 0, 1, 4'b0010), "buy1_last");
    add(NOP(1),         O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010), "disp_to_idle");
    // Insufficient credit, then cancel.
    add(COIN(3, 1),     O(0, 0, 0, 2'b00, 3, 0, 0, 0, 4'b0010), "coin3");
    add(BUY(3),         O(0, 0, 1, 2'b01, 3, 0, 0, 0, 4'b0010), "buy3_insuff");
    add(CANCEL(1),      O(0, 0, 0, 2'b00, 3, 1, 3, 1, 4'b0010), "cancel3");
    add(NOP(1),         O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010), "refund_done");
    // Sold-out item.
    add(PROG(2, 8, 0),  O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0110), "prog2_empty");
    add(COIN(5, 1),     O(0, 0, 0, 2'b00, 5, 0, 0, 0, 4'b0110), "coin5a");
    add(COIN(5, 1),     O(0, 0, 0, 2'b00, 10, 0, 0, 0, 4'b0110), "coin5b");
    add(BUY(2),         O(0, 0, 1, 2'b10, 10, 0, 0, 0, 4'b0110), "buy2_soldout");
    // Cancel 12 with the hopper stalled, coin and buy ignored/rejected meanwhile.
    add(COIN(2, 1),     O(0, 0, 0, 2'b00, 12, 0, 0, 0, 4'b0110), "coin2");
    add(CANCEL(0),      O(0, 0, 0, 2'b00, 12, 1, 5, 1, 4'b0110), "cancel12");
    add(COIN(1, 0),     O(0, 0, 1, 2'b11, 12, 1, 5, 1, 4'b0110), "coin_in_change");
    add(BUY(0),         O(0, 0, 0, 2'b00, 12, 1, 5, 1, 4'b0110), "buy_in_change");
    add(NOP(0),         O(0, 0, 0, 2'b00, 12, 1, 5, 1, 4'b0110), "stall_hold");
    add(NOP(1),         O(0, 0, 0, 2'b00, 7, 1, 5, 1, 4'b0110), "beat5a");
    add(NOP(1),         O(0, 0, 0, 2'b00, 2, 1, 2, 1, 4'b0110), "beat5b");
    add(NOP(1),         O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0110), "beat2_done");

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i, tbl[k].name, tbl[k].o);
    end

    // Fill credit to 252 with 7-coins, then probe the overflow boundary.
    for (int k = 1; k <= 36; k++) begin
      step(COIN(7, 1), $sformatf("fill_%0d", k), O(0, 0, 0, 2'b00, 8'(7 * k), 0, 0, 0, 4'b0110));
    end
    step(COIN(7, 1), "ovf_reject7", O(0, 0, 1, 2'b11, 252, 0, 0, 0, 4'b0110));
    step(COIN(3, 1), "fill_255",    O(0, 0, 0, 2'b00, 255, 0, 0, 0, 4'b0110));
    step(COIN(1, 1), "ovf_reject1", O(0, 0, 1, 2'b11, 255, 0, 0, 0, 4'b0110));
    step(CANCEL(1),  "cancel255",   O(0, 0, 0, 2'b00, 255, 1, 5, 1, 4'b0110));

    // Drain 255 at full hopper rate: 51 beats of 5.
    drive(NOP(1'b1));
    beats = 0;
    total = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (!bus.chg_valid) break;
      beats++;
      total += int'(bus.chg_amt);
      @(posedge clk);
      #1;
    end
    check_int("drain_beats", beats, 51);
    check_int("drain_total", total, 255);
    check("drain_idle", O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0110));

    // Reset in the middle of a change drain.
    step(COIN(7, 1), "coin7_pre_rst", O(0, 0, 0, 2'b00, 7, 0, 0, 0, 4'b0110));
    step(CANCEL(0),  "cancel7",       O(0, 0, 0, 2'b00, 7, 1, 5, 1, 4'b0110));
    drive(NOP(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1111));
    @(posedge clk);
    #1;
    check("reset_held", O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1111));
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: free vend, coin accepted, programming ignored outside IDLE.
    step(PROG(0, 0, 1), "prog_free",    O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1110));
    step(BUY(0),        "free_vend",    O(1, 0, 0, 2'b00, 0, 0, 0, 1, 4'b1111));
    step(NOP(0),        "free_idle",    O(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1111));
    step(COIN(4, 0),    "coin_post",    O(0, 0, 0, 2'b00, 4, 0, 0, 0, 4'b1111));
    step(PROG(0, 9, 3), "prog_collect", O(0, 0, 0, 2'b00, 4, 0, 0, 0, 4'b1111));
    step(BUY(0),        "buy_cleared",  O(0, 0, 1, 2'b10, 4, 0, 0, 0, 4'b1111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vend_datapath_n.md
Name: vend_datapath_n

Overview:
- Parametrised successor to the fixed four-item vending datapath.
- Supports N items, with price and stock programmable at run time.
- Enforces per-item stock, rejects coins on overflow, and reports errors as coded pulses.
- Returns change one coin per beat over a valid/ready handshake.
- Sits between the coin acceptor / keypad front-end and the dispenser / change-hopper drivers.

Parameters:
- NUM_ITEMS, 4: number of selectable items; SEL_W = max(1, $clog2(NUM_ITEMS)).
- PRICE_W, 8: width of balance and price registers.
- MONEY_W, 3: width of one inserted coin value.
- STOCK_W, 4: width of the per-item stock counter.
- MAX_COIN, 5: largest change coin value paid per beat. Must be at least 1 and at most 2^MONEY_W-1.

Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- money in MONEY_W: value of the inserted coin.
- money_valid in 1: coin present this cycle.
- sel in SEL_W: item selection.
- buy in 1: purchase request, sampled each cycle.
- cancel in 1: refund request.
- prog_en in 1: write price and stock for prog_idx.
- prog_idx in SEL_W: item index to program.
- prog_price in PRICE_W: price value to write.
- prog_stock in STOCK_W: stock value to write.
- chg_ready in 1: hopper accepted the current change coin.
- dispense out 1: one-cycle pulse releasing an item.
- dispense_idx out SEL_W: item released, valid with dispense.
- error out 1: one-cycle error pulse.
- err_code out 2: 00 none, 01 insufficient, 10 sold out, 11 coin rejected. Valid with error.
- balance out PRICE_W: current credit.
- chg_valid out 1: change coin offered.
- chg_amt out MONEY_W: value of the offered coin.
- busy out 1: high in DISPENSE or CHANGE.
- sold_out out NUM_ITEMS: bit i set when stock[i]==0.

Behaviour:
- All outputs are registered.
- On reset low, the following clear asynchronously: state=IDLE; balance, all prices and all stock = 0; dispense, error, err_code, chg_valid, chg_amt = 0; sold_out = all ones.
- Reset mid-CHANGE or mid-DISPENSE abandons the transaction; no pulse completes.
- States:
  - IDLE: balance==0.
  - COLLECT: balance>0.
  - DISPENSE: one cycle.
  - CHANGE: drain credit.
- IDLE/COLLECT per-cycle priority: cancel > buy > money_valid > prog_en. Lower-priority requests in the same cycle are dropped with no error.
- Coin handling (money_valid):
  - If balance+money ≤ 2^PRICE_W-1: balance += money next cycle; go to COLLECT if the result is nonzero.
  - Otherwise: coin rejected, balance unchanged, error pulse with code 11.
- buy:
  - stock[sel]==0: error code 10; state and balance unchanged.
  - Else if balance < price[sel]: error code 01; balance retained.
  - Else, at the sampling edge: balance -= price[sel], stock[sel] -= 1, enter DISPENSE. dispense=1 and dispense_idx=sel for exactly one cycle.
  - From DISPENSE: go to CHANGE if balance>0, else IDLE.
  - Price 0 with stock>0 is a legal free vend.
- cancel in COLLECT: enter CHANGE with the full balance. cancel in IDLE: no effect.
- CHANGE:
  - chg_valid=1, chg_amt = min(balance, MAX_COIN).
  - chg_amt is held stable while chg_ready is low.
  - On chg_valid & chg_ready: balance -= chg_amt.
  - When balance reaches 0, chg_valid drops the following cycle and state goes to IDLE.
- In DISPENSE/CHANGE:
  - money_valid gives error code 11; coin rejected.
  - buy and cancel are ignored with no error.
  - prog_en is ignored.
- prog_en is honoured only in IDLE. It writes price and stock for prog_idx next cycle. Out-of-range prog_idx or sel (NUM_ITEMS not a power of 2) is ignored; an out-of-range buy gives error code 10.
- Latencies:
  - balance visible 1 cycle after the coin.
  - dispense 1 cycle after buy.
  - first chg_valid 1 cycle after DISPENSE, or 1 cycle after cancel.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE).
  - err_code constants: ERR_NONE, ERR_INSUFF, ERR_SOLDOUT, ERR_REJECT.
- Sub-module vend_item_table:
  - NUM_ITEMS × (price, stock) register file.
  - Async active-low reset.
  - Program-write port, decrement port, combinational read by sel.
  - sold_out vector output.

Test Plan:
- Program prices 5/7/8/10 and stock 2 each. Insert 4,4; buy sel=1 → dispense with idx 1; balance 1; chg_amt=1 beat; return to IDLE; stock[1]=1.
- Insert 3; buy sel=3 → error with code 01, balance stays 3. Then cancel → one chg beat of 3, then IDLE.
- Program stock[2]=0; insert 5,5; buy sel=2 → error code 10; sold_out[2]=1; balance 10 retained.
- Balance 12; cancel with chg_ready low for 3 cycles → chg_amt=5 held stable. Then ready high → beats 5, 5, 2 and balance 0.
- Reach balance 252 (PRICE_W=8); insert 7 → error code 11, balance 252. Insert 3 → balance 255.
- Assert reset low mid-CHANGE with balance 7 → all outputs zero immediately, sold_out all ones, prices cleared. Insert a coin after release → accepted normally.
